// File: rtl/reg_file_16b.sv
// reg_file_16b: 16x16 register file, two registered forwarding read ports, one write port, zero r0
module reg_file_16b #(
    parameter logic [15:0] SP_INIT = 16'hBEEF,
    parameter logic [3:0]  SP_ADDR = 4'd1
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        write,
    input  logic [3:0]  wAddr,
    input  logic [15:0] wData,
    input  logic [3:0]  rAddrA,
    input  logic [3:0]  rAddrB,
    input  logic        rEn,
    output logic [15:0] QA,
    output logic [15:0] QB,
    output logic        rValid,
    output logic [15:0] spOut
);
    logic [15:0] regs [16];
    logic [15:0] fwd_a, fwd_b;
    logic        wr_ok;

    assign wr_ok = write && (wAddr != 4'd0);
    assign spOut = (SP_ADDR == 4'd0) ? 16'h0000 : regs[SP_ADDR];

    // read values with r0 forced to zero and a same-cycle write forwarded
    always_comb begin
        fwd_a = (rAddrA == 4'd0) ? 16'h0000 : (wr_ok && wAddr == rAddrA) ? wData : regs[rAddrA];
        fwd_b = (rAddrB == 4'd0) ? 16'h0000 : (wr_ok && wAddr == rAddrB) ? wData : regs[rAddrB];
    end

    // storage and output registers; reset wins over any pending write or read
    always_ff @(posedge CLK) begin
        if (reset) begin
            for (int i = 0; i < 16; i++)
                regs[i] <= (4'(i) == SP_ADDR && SP_ADDR != 4'd0) ? SP_INIT : 16'h0000;
            QA     <= 16'h0000;
            QB     <= 16'h0000;
            rValid <= 1'b0;
        end else begin
            if (wr_ok)
                regs[wAddr] <= wData;
            if (rEn) begin
                QA <= fwd_a;
                QB <= fwd_b;
            end
            rValid <= rEn;
        end
    end
endmodule

// File: tb/tb_reg_file_16b.sv
// tb_reg_file_16b: directed bench with a reference model and per-cycle comparison
module tb_reg_file_16b;
    logic        CLK = 1'b0;
    logic        reset, write, rEn;
    logic [3:0]  wAddr, rAddrA, rAddrB;
    logic [15:0] wData;
    logic [15:0] QA, QB, spOut;
    logic        rValid;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    logic [15:0] mem [16];
    logic [15:0] m_qa, m_qb;
    logic        m_rv;

    reg_file_16b dut (
        .CLK(CLK), .reset(reset), .write(write), .wAddr(wAddr), .wData(wData),
        .rAddrA(rAddrA), .rAddrB(rAddrB), .rEn(rEn),
        .QA(QA), .QB(QB), .rValid(rValid), .spOut(spOut)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] value_of(input logic [3:0] x);
        if (x == 0) return 16'h0000;
        if (write && wAddr == x) return wData;
        return mem[x];
    endfunction

    task automatic step();
        @(posedge CLK);
        if (reset) begin
            foreach (mem[i]) mem[i] = 16'h0000;
            mem[1] = 16'hBEEF;
            m_qa = 0; m_qb = 0; m_rv = 0;
        end else begin
            if (rEn) begin
                m_qa = value_of(rAddrA);
                m_qb = value_of(rAddrB);
            end
            m_rv = rEn;
            if (write && wAddr != 0) mem[wAddr] = wData;
        end
        #1;
    endtask

    always @(negedge CLK) begin
        if (chk_en) begin
            chk("model_qa", QA, m_qa);
            chk("model_qb", QB, m_qb);
            chk("model_rvalid", {15'd0, rValid}, {15'd0, m_rv});
            chk("model_sp", spOut, mem[1]);
        end
    end

    initial begin
        reset = 1; write = 0; rEn = 0; wAddr = 0; rAddrA = 0; rAddrB = 0; wData = 0;
        step(); step();
        chk_en = 1'b1;
        chk("rst_qa", QA, 16'h0000);
        chk("rst_rvalid", {15'd0, rValid}, 16'h0000);
        chk("rst_sp", spOut, 16'hBEEF);
        reset = 0;
        rEn = 1; rAddrA = 1; rAddrB = 2; step();
        chk("rd_sp_qa", QA, 16'hBEEF);
        chk("rd_r2_qb", QB, 16'h0000);
        chk("rd_rvalid", {15'd0, rValid}, 16'h0001);
        rEn = 0; step();
        chk("rvalid_pulse", {15'd0, rValid}, 16'h0000);
        chk("qa_hold", QA, 16'hBEEF);
        write = 1; wAddr = 5; wData = 16'h0045; step();
        write = 0; wData = 16'd420; rEn = 1; rAddrA = 5; step();
        chk("wr_r5", QA, 16'h0045);
        step();
        chk("nowr_r5", QA, 16'h0045);
        write = 1; wAddr = 7; wData = 16'h1234; rAddrA = 7; rAddrB = 7; step();
        chk("fwd_qa", QA, 16'h1234);
        chk("fwd_qb", QB, 16'h1234);
        chk("fwd_sp", spOut, 16'hBEEF);
        wAddr = 0; wData = 16'hFFFF; rAddrA = 0; rAddrB = 0; step();
        chk("r0_fwd_qa", QA, 16'h0000);
        chk("r0_fwd_qb", QB, 16'h0000);
        write = 0; step();
        chk("r0_qa", QA, 16'h0000);
        rEn = 0; write = 1; wAddr = 1; wData = 16'h0100; step();
        chk("sp_wr", spOut, 16'h0100);
        reset = 1; wData = 16'h5555; rEn = 1; rAddrA = 1; step();
        chk("rst_mid_sp", spOut, 16'hBEEF);
        chk("rst_mid_qa", QA, 16'h0000);
        chk("rst_mid_rv", {15'd0, rValid}, 16'h0000);
        reset = 0; write = 0; rAddrB = 5; step();
        chk("post_rst_qa", QA, 16'hBEEF);
        chk("post_rst_qb", QB, 16'h0000);
        rEn = 0; write = 1;
        for (int i = 3; i <= 5; i++) begin
            wAddr = 4'(i); wData = 16'(i); step();
        end
        write = 0; rEn = 1;
        for (int i = 3; i <= 5; i++) begin
            rAddrA = 4'(i); step();
            chk("seq_qa", QA, 16'(i));
            chk("seq_rv", {15'd0, rValid}, 16'h0001);
        end
        rEn = 0; step();
        chk("seq_hold", QA, 16'h0005);
        chk("seq_rv_off", {15'd0, rValid}, 16'h0000);
        for (int i = 0; i < 60; i++) begin
            write  = 1'($urandom_range(0, 1));
            wAddr  = 4'($urandom_range(0, 15));
            wData  = 16'($urandom);
            rEn    = 1'($urandom_range(0, 1));
            rAddrA = (i % 4 == 0) ? wAddr : 4'($urandom_range(0, 15));
            rAddrB = 4'($urandom_range(0, 15));
            reset  = (i == 40);
            step();
        end
        reset = 0; write = 0; rEn = 0; step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
